// File: rtl/vga_pattern_gen_pkg.sv
// vga_pattern_gen_pkg: pattern codes and default 640x480 timing shared by the pattern generator files
package vga_pattern_gen_pkg;
    localparam int DEF_VIDEO_WIDTH = 3;
    localparam int DEF_TOTAL_COLS  = 800;
    localparam int DEF_TOTAL_ROWS  = 525;
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    typedef enum logic [3:0] {
        PAT_BLACK    = 4'd0,
        PAT_RED      = 4'd1,
        PAT_GREEN    = 4'd2,
        PAT_BLUE     = 4'd3,
        PAT_CHECKER  = 4'd4,
        PAT_BARS     = 4'd5,
        PAT_BORDER   = 4'd6,
        PAT_GRADIENT = 4'd7
    } pattern_e;
endpackage

// File: rtl/vga_pos_counter.sv
// vga_pos_counter: VSync rise detect, free-running column/row counters and stage-1 sync/frame-start registers
module vga_pos_counter
    import vga_pattern_gen_pkg::*;
#(
    parameter int TOTAL_COLS = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic       rise_o,
    output logic       col_clr_o,
    output logic [9:0] col_o,
    output logic [9:0] row_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       frame_start_o,
    output logic       valid_o
);
    localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
    logic       vs_prev_q, hs_q, vs_q, fs_q, valid_q;
    logic [9:0] col_q, col_d, row_q, row_d;
    assign rise_o    = vsync_i & ~vs_prev_q;
    assign col_clr_o = rise_o | (col_q == LAST_COL);
    // Next position: resync to (0,0) on a VSync rise, otherwise count with line and frame wrap
    always_comb begin
        col_d = col_clr_o ? '0 : col_q + 10'd1;
        row_d = rise_o ? '0 : (col_q != LAST_COL) ? row_q : (row_q == LAST_ROW) ? '0 : row_q + 10'd1;
    end
    // Stage-1 registers; prev VSync resets high so a reset inside VSync cannot fake a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev_q <= 1'b1;
            col_q     <= '0;
            row_q     <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            vs_prev_q <= vsync_i;
            col_q     <= col_d;
            row_q     <= row_d;
            hs_q      <= hsync_i;
            vs_q      <= vsync_i;
            fs_q      <= rise_o;
            valid_q   <= valid_q | rise_o;
        end
    end
    assign col_o         = col_q;
    assign row_o         = row_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_start_o = fs_q;
    assign valid_o       = valid_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: switch-selected VGA test patterns with 2-clk re-timed syncs; optional crosshair via VGA_PATTERN_GEN_CROSSHAIR_EN
module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int VIDEO_WIDTH = DEF_VIDEO_WIDTH,
    parameter int TOTAL_COLS  = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS  = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [3:0]             i_Pattern,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Frame_Start
);
    localparam logic [9:0] AC       = 10'(ACTIVE_COLS);
    localparam logic [9:0] AR       = 10'(ACTIVE_ROWS);
    localparam logic [9:0] BAR_LAST = 10'(ACTIVE_COLS / 8 - 1);
`ifdef VGA_PATTERN_GEN_CROSSHAIR_EN
    localparam logic [9:0] MID_COL  = 10'(ACTIVE_COLS / 2);
    localparam logic [9:0] MID_ROW  = 10'(ACTIVE_ROWS / 2);
`endif
    localparam logic [VIDEO_WIDTH-1:0] FULL = '1;
    logic                   rise, col_clr, hs1, vs1, fs1, valid, active, white;
    logic [9:0]             col, row, wid_q;
    logic [2:0]             bar_q;
    logic [3:0]             pat_q;
    logic [VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;

    vga_pos_counter #(
        .TOTAL_COLS(TOTAL_COLS),
        .TOTAL_ROWS(TOTAL_ROWS)
    ) u_pos (
        .clk          (i_Clk),
        .rst          (i_Rst),
        .hsync_i      (i_HSync),
        .vsync_i      (i_VSync),
        .rise_o       (rise),
        .col_clr_o    (col_clr),
        .col_o        (col),
        .row_o        (row),
        .hsync_o      (hs1),
        .vsync_o      (vs1),
        .frame_start_o(fs1),
        .valid_o      (valid)
    );

    // Pattern latch (frame start only) and divider-free bar index tracking the stage-1 column
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            pat_q <= '0;
            wid_q <= '0;
            bar_q <= '0;
        end else begin
            if (rise) pat_q <= i_Pattern;
            if (col_clr) begin
                wid_q <= '0;
                bar_q <= '0;
            end else if (wid_q == BAR_LAST) begin
                wid_q <= '0;
                bar_q <= bar_q + 3'd1;
            end else begin
                wid_q <= wid_q + 10'd1;
            end
        end
    end

    // Colour mux for the stage-1 position; blanking and pre-frame-start suppression applied last
    always_comb begin
        red_d  = '0;
        grn_d  = '0;
        blu_d  = '0;
        active = valid && (col < AC) && (row < AR);
        white  = 1'b0;
        case (pat_q)
            PAT_BLACK:    ;
            PAT_RED:      red_d = FULL;
            PAT_GREEN:    grn_d = FULL;
            PAT_BLUE:     blu_d = FULL;
            PAT_CHECKER:  white = col[5] ^ row[5];
            PAT_BARS: begin
                red_d = {VIDEO_WIDTH{bar_q[2]}};
                grn_d = {VIDEO_WIDTH{bar_q[1]}};
                blu_d = {VIDEO_WIDTH{bar_q[0]}};
            end
            PAT_BORDER:   white = (col == 10'd0) || (col == AC - 10'd1) || (row == 10'd0) || (row == AR - 10'd1);
            PAT_GRADIENT: begin
                red_d = col[9 -: VIDEO_WIDTH];
                grn_d = row[8 -: VIDEO_WIDTH];
            end
            default:      ;
        endcase
`ifdef VGA_PATTERN_GEN_CROSSHAIR_EN
        if ((col == MID_COL) || (row == MID_ROW)) white = 1'b1;
`endif
        if (white) {red_d, grn_d, blu_d} = {FULL, FULL, FULL};
        if (!active) {red_d, grn_d, blu_d} = '0;
    end

    // Stage-2 output registers; syncs held low until the first frame start after reset
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
        end else begin
            o_HSync       <= hs1 & valid;
            o_VSync       <= vs1 & valid;
            o_Frame_Start <= fs1;
            o_Red_Video   <= red_d;
            o_Grn_Video   <= grn_d;
            o_Blu_Video   <= blu_d;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: reduced-geometry frames, per-cycle reference model plus a table of fixed pixel expectations
module tb_vga_pattern_gen;
    localparam int VW = 9;
    localparam int TC = 660;
    localparam int TR = 8;
    localparam int AC = 640;
    localparam int AR = 6;
    localparam logic [VW-1:0] F = '1;
`ifdef VGA_PATTERN_GEN_CROSSHAIR_EN
    localparam int X = 511;
`else
    localparam int X = 0;
`endif

    typedef struct packed {
        logic hs, vs, fs;
        logic [VW-1:0] r, g, b;
    } out_t;
    typedef struct {
        int f, c, r, er, eg, eb;
    } vec_t;

    logic i_Clk = 0, i_Rst = 1, i_HSync = 0, i_VSync = 0;
    logic [3:0] i_Pattern = 0;
    logic o_HSync, o_VSync, o_Frame_Start;
    logic [VW-1:0] o_Red_Video, o_Grn_Video, o_Blu_Video;
    int errors = 0, checks = 0;
    int bf = -1, bc = 0, br = 0;
    vec_t tbl[$];
    int hit[$];
    logic [3:0] fpat[12];

    vga_pattern_gen #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR)
    ) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_HSync(i_HSync), .i_VSync(i_VSync), .i_Pattern(i_Pattern),
        .o_HSync(o_HSync), .o_VSync(o_VSync), .o_Red_Video(o_Red_Video), .o_Grn_Video(o_Grn_Video),
        .o_Blu_Video(o_Blu_Video), .o_Frame_Start(o_Frame_Start)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input int f, input int c, input int r, input int er, input int eg, input int eb);
        tbl.push_back('{f, c, r, er, eg, eb});
        hit.push_back(0);
    endtask

    // Expected colour of pixel (c,r) under pattern p, from the pattern definitions
    function automatic out_t pix(input int c, input int r, input logic [3:0] p);
        logic [VW-1:0] rr, gg, bb;
        logic w;
        int bar;
        out_t o;
        rr = '0; gg = '0; bb = '0; w = 0;
        bar = c / (AC / 8);
        case (p)
            4'd1: rr = F;
            4'd2: gg = F;
            4'd3: bb = F;
            4'd4: w = (((c / 32) + (r / 32)) % 2) == 1;
            4'd5: begin
                rr = (bar & 4) != 0 ? F : '0;
                gg = (bar & 2) != 0 ? F : '0;
                bb = (bar & 1) != 0 ? F : '0;
            end
            4'd6: w = (c == 0) || (c == AC - 1) || (r == 0) || (r == AR - 1);
            4'd7: begin
                rr = VW'(c >> (10 - VW));
                gg = VW'(r >> (9 - VW));
            end
            default: ;
        endcase
`ifdef VGA_PATTERN_GEN_CROSSHAIR_EN
        if (c == AC / 2 || r == AR / 2) w = 1;
`endif
        if (w) begin rr = F; gg = F; bb = F; end
        if (c >= AC || r >= AR) begin rr = '0; gg = '0; bb = '0; end
        o.hs = 0; o.vs = 0; o.fs = 0; o.r = rr; o.g = gg; o.b = bb;
        return o;
    endfunction

    // Reference model: tracks frame starts and position, compares every cycle and the fixed table
    initial begin
        out_t item, expv, got;
        logic m_prev, m_valid, rise;
        logic [3:0] m_pat;
        int m_pos, qf, qc, qr, xf, xc, xr;
        item = '0; m_prev = 1; m_valid = 0; m_pat = 0; m_pos = 0;
        qf = -1; qc = 0; qr = 0;
        forever begin
            @(posedge i_Clk);
            expv = i_Rst ? '0 : item;
            xf = qf; xc = qc; xr = qr;
            if (i_Rst) begin
                m_prev = 1; m_valid = 0; m_pat = 0; m_pos = 0; item = '0;
            end else begin
                rise = i_VSync && !m_prev;
                if (rise) begin
                    m_pos = 0; m_pat = i_Pattern; m_valid = 1;
                end else m_pos = (m_pos + 1) % (TC * TR);
                m_prev = i_VSync;
                item = pix(m_pos % TC, m_pos / TC, m_pat);
                item.hs = i_HSync; item.vs = i_VSync; item.fs = rise;
                if (!m_valid) item = '0;
            end
            qf = bf; qc = bc; qr = br;
            @(negedge i_Clk);
            got.hs = o_HSync; got.vs = o_VSync; got.fs = o_Frame_Start;
            got.r = o_Red_Video; got.g = o_Grn_Video; got.b = o_Blu_Video;
            chk($sformatf("model f%0d (%0d,%0d)", xf, xc, xr), 64'(got), 64'(expv));
            for (int i = 0; i < tbl.size(); i++)
                if (tbl[i].f == xf && tbl[i].c == xc && tbl[i].r == xr) begin
                    hit[i]++;
                    chk($sformatf("table%0d f%0d (%0d,%0d) rgb", i, xf, xc, xr),
                        64'({got.r, got.g, got.b}), 64'({VW'(tbl[i].er), VW'(tbl[i].eg), VW'(tbl[i].eb)}));
                end
        end
    end

    // First frame start after the mid-frame reset appears 2 clk after the VSync rise
    initial begin
        int k;
        wait (bf == 7);
        for (k = 1; k < 50; k++) begin
            @(posedge i_Clk);
            @(negedge i_Clk);
            if (o_Frame_Start) break;
        end
        chk("fs_delay_after_reset", 64'(k), 64'd2);
    end

    // Outputs stay black/low once a mid-frame reset is released
    initial begin
        wait (bf == 6 && i_Rst);
        wait (!i_Rst);
        repeat (5) begin
            @(negedge i_Clk);
            chk("post_reset_zero", 64'({o_HSync, o_VSync, o_Frame_Start, o_Red_Video, o_Grn_Video, o_Blu_Video}), 64'd0);
        end
    end

    initial begin
        add(0, 0, 0, F, 0, 0);   add(0, 640, 0, 0, 0, 0); add(0, 0, 6, 0, 0, 0);   add(0, 639, 5, F, 0, 0);
        add(1, 0, 0, 0, 0, 0);   add(1, 79, 1, 0, 0, 0);  add(1, 80, 0, 0, 0, F);  add(1, 160, 1, 0, F, 0);
        add(1, 400, 2, F, 0, F); add(1, 560, 1, F, F, F); add(1, 639, 5, F, F, F);
        add(2, 32, 0, F, F, F);  add(2, 0, 0, 0, 0, 0);   add(2, 64, 1, 0, 0, 0);  add(2, 32, 5, F, F, F);
        add(3, 10, 0, 0, F, 0);  add(3, 600, 5, 0, F, 0);
        add(4, 512, 0, 256, 0, 0); add(4, 0, 5, 0, 5, 0); add(4, 639, 4, 319, 4, 0); add(4, 511, 2, 255, 2, 0);
        add(5, 100, 1, 0, 0, 0);
        add(6, 0, 1, F, F, F);   add(6, 639, 1, F, F, F); add(6, 5, 0, F, F, F);   add(6, 5, 1, 0, 0, 0);
        add(6, 5, 5, 0, 0, 0);
        add(7, 10, 1, 0, 0, F);  add(7, 0, 5, 0, 0, F);
        add(8, 10, 1, 0, 0, F);  add(8, 10, 6, 0, 0, 0);
        add(9, 321, 1, 0, 0, 0); add(9, 10, 2, 0, 0, 0);  add(9, 320, 1, X, X, X); add(9, 10, 3, X, X, X);
        fpat = '{4'd1, 4'd5, 4'd4, 4'd2, 4'd7, 4'($urandom_range(8, 15)), 4'd6, 4'd3, 4'd0, 4'd0,
                 4'($urandom_range(0, 15)), 4'd0};
        repeat (3) @(posedge i_Clk);
        #1 i_Rst = 0;
        repeat (2) @(posedge i_Clk);
        #1;
        for (int f = 0; f < 11; f++) begin
            for (int r = 0; r < TR; r++)
                for (int c = 0; c < TC; c++) begin
                    bf = f; bc = c; br = r;
                    if (r == 0 && c == 0) i_Pattern = fpat[f];
                    if (r == 4 && c == 0) i_Pattern = fpat[f + 1];
                    if (f == 10 && r > 0 && c == 0) i_Pattern = 4'($urandom_range(0, 15));
                    i_Rst = (f == 6 && r == 2 && c < 3);
                    i_HSync = c < AC;
                    i_VSync = r < AR && f != 8;
                    @(posedge i_Clk);
                    #1;
                end
        end
        bf = -1; i_HSync = 0; i_VSync = 0;
        repeat (4) @(posedge i_Clk);
        @(negedge i_Clk);
        for (int i = 0; i < tbl.size(); i++)
            if (hit[i] == 0) begin
                errors++;
                $display("FAIL table%0d not reached: hits 0 expected 1", i);
            end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
